// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - shared width and ALUControl encodings for the MIPS ALU
package mips_alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_if.sv
// rtl/mips_alu_if.sv - operand/result bundle for mips_alu; Overflow exists only with MIPS_ALU_OVERFLOW_EN
interface mips_alu_if;
   import mips_alu_pkg::*;

   logic [DATA_W-1:0] SrcA;
   logic [DATA_W-1:0] SrcB;
   logic [2:0]        ALUControl;
   logic [DATA_W-1:0] ALUResult;
   logic              Zero;
   logic [DATA_W-1:0] ALUResultQ;
   logic              ZeroQ;
`ifdef MIPS_ALU_OVERFLOW_EN
   logic              Overflow;

   modport master (output SrcA, SrcB, ALUControl,
                   input  ALUResult, Zero, ALUResultQ, ZeroQ, Overflow);
   modport slave  (input  SrcA, SrcB, ALUControl,
                   output ALUResult, Zero, ALUResultQ, ZeroQ, Overflow);
`else
   modport master (output SrcA, SrcB, ALUControl,
                   input  ALUResult, Zero, ALUResultQ, ZeroQ);
   modport slave  (input  SrcA, SrcB, ALUControl,
                   output ALUResult, Zero, ALUResultQ, ZeroQ);
`endif

endinterface

// File: rtl/mips_alu_addsub.sv
// rtl/mips_alu_addsub.sv - shared 32-bit adder/subtractor with signed overflow
module mips_alu_addsub
   import mips_alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sub,
   output logic [DATA_W-1:0] sum,
   output logic              overflow
);

   logic [DATA_W-1:0] b_eff;

   // Subtraction is a + ~b + 1: invert b and feed sub in as the carry-in.
   assign b_eff = b ^ {DATA_W{sub}};
   assign sum   = a + b_eff + {{(DATA_W-1){1'b0}}, sub};

   // Signed overflow: effective operands agree in sign but the sum does not.
   assign overflow = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - single-cycle MIPS ALU with registered result copy; optional MIPS_ALU_OVERFLOW_EN
module mips_alu
   import mips_alu_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   mips_alu_if.slave alu
);

   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] result;
   logic              ovf;
   logic              sub;
   logic              zero;
   logic              slt_bit;

   // SUB and SLT both run the adder in subtract mode.
   assign sub = (alu.ALUControl == ALU_SUB) || (alu.ALUControl == ALU_SLT);

   mips_alu_addsub u_addsub (
      .a        (alu.SrcA),
      .b        (alu.SrcB),
      .sub      (sub),
      .sum      (sum),
      .overflow (ovf)
   );

   // Sign of A-B corrected for overflow gives the true signed less-than.
   assign slt_bit = sum[DATA_W-1] ^ ovf;

   // Operation decode; unused codes produce zero.
   always_comb begin
      result = '0;
      case (alu.ALUControl)
         ALU_AND: result = alu.SrcA & alu.SrcB;
         ALU_OR:  result = alu.SrcA | alu.SrcB;
         ALU_ADD: result = sum;
         ALU_SUB: result = sum;
         ALU_SLT: result = {{(DATA_W-1){1'b0}}, slt_bit};
         default: result = '0;
      endcase
   end

   assign zero          = ~|result;
   assign alu.ALUResult = result;
   assign alu.Zero      = zero;

`ifdef MIPS_ALU_OVERFLOW_EN
   assign alu.Overflow = ((alu.ALUControl == ALU_ADD) || (alu.ALUControl == ALU_SUB)) && ovf;
`endif

   // Pipeline copy of result and zero flag, loaded every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu.ALUResultQ <= '0;
         alu.ZeroQ      <= 1'b0;
      end else begin
         alu.ALUResultQ <= result;
         alu.ZeroQ      <= zero;
      end
   end

endmodule

// File: tb/tb_mips_alu.sv
// tb/tb_mips_alu.sv - scoreboard testbench for mips_alu; Overflow checked with MIPS_ALU_OVERFLOW_EN
module tb_mips_alu;
   import mips_alu_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t comb_q[$];
   exp_t reg_q[$];

   always #5 clk = ~clk;

   mips_alu_if bus ();

   mips_alu dut (
      .clk   (clk),
      .reset (reset),
      .alu   (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      exp_t   e;
      longint s;
      e.res = 32'd0;
      e.ovf = 1'b0;
      case (c)
         3'b000: e.res = a & b;
         3'b001: e.res = a | b;
         3'b010: begin
            e.res = a + b;
            s = longint'($signed(a)) + longint'($signed(b));
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'b110: begin
            e.res = a - b;
            s = longint'($signed(a)) - longint'($signed(b));
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'b111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: e.res = 32'd0;
      endcase
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      exp_t e;
      exp_t g;
      @(negedge clk);
      bus.SrcA       = a;
      bus.SrcB       = b;
      bus.ALUControl = c;
      e = model(a, b, c);
      comb_q.push_back(e);
      reg_q.push_back(e);
      #1;
      g = comb_q.pop_front();
      check("result", bus.ALUResult, g.res);
      check("zero", {31'd0, bus.Zero}, {31'd0, g.zero});
`ifdef MIPS_ALU_OVERFLOW_EN
      check("overflow", {31'd0, bus.Overflow}, {31'd0, g.ovf});
`endif
      @(posedge clk);
      #1;
      g = reg_q.pop_front();
      check("result_q", bus.ALUResultQ, g.res);
      check("zero_q", {31'd0, bus.ZeroQ}, {31'd0, g.zero});
   endtask

   initial begin
      reset          = 1'b1;
      bus.SrcA       = 32'd15;
      bus.SrcB       = 32'd10;
      bus.ALUControl = ALU_AND;
      #2;
      check("reset_result_q", bus.ALUResultQ, 32'd0);
      check("reset_zero_q", {31'd0, bus.ZeroQ}, 32'd0);
      check("reset_comb", bus.ALUResult, 32'd10);
      @(negedge clk);
      reset = 1'b0;

      // Basic decode with 15/10, including the unused codes.
      for (int c = 0; c < 8; c++) apply(32'd15, 32'd10, 3'(c));
      apply(32'd42, 32'd42, ALU_SUB);

      // Signed compare and wraparound corners.
      apply(32'hFFFF_FFFF, 32'd1, ALU_SLT);
      apply(32'h7FFF_FFFF, 32'h8000_0000, ALU_SLT);
      apply(32'h8000_0000, 32'h7FFF_FFFF, ALU_SLT);
      apply(32'h8000_0000, 32'h8000_0000, ALU_SLT);
      apply(32'hFFFF_FFFF, 32'd1, ALU_ADD);
      apply(32'h7FFF_FFFF, 32'd1, ALU_ADD);
      apply(32'h8000_0000, 32'd1, ALU_SUB);
      apply(32'h8000_0000, 32'd1, ALU_AND);
      apply(32'h8000_0000, 32'h8000_0000, ALU_ADD);
      apply(32'd0, 32'h8000_0000, ALU_SUB);

      for (int i = 0; i < 24; i++)
         apply($urandom, $urandom, 3'($urandom_range(0, 7)));

      // Asynchronous reset between edges, then recovery.
      apply(32'd2, 32'd3, ALU_ADD);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_q", bus.ALUResultQ, 32'd0);
      check("async_reset_zq", {31'd0, bus.ZeroQ}, 32'd0);
      check("async_reset_comb", bus.ALUResult, 32'd5);
      @(posedge clk);
      #1;
      check("held_reset_q", bus.ALUResultQ, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("released_q", bus.ALUResultQ, 32'd0);
      check("released_zq", {31'd0, bus.ZeroQ}, 32'd0);
      @(posedge clk);
      #1;
      check("first_edge_q", bus.ALUResultQ, 32'd5);
      check("first_edge_zq", {31'd0, bus.ZeroQ}, 32'd0);

      check("queue_drained", 32'(comb_q.size() + reg_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
